// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver with a frame-synchronous display register.
// Optional build macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
module seven_seg_scan #(
    parameter int CLK_DIV = 12000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [15:0] digits,
    input  logic        digits_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       index;
    logic [15:0]      shadow;
    logic [15:0]      display;
    logic             tick;
    logic             frame_edge;
    logic [3:0]       cur_digit;
    logic             cur_blank;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}; 10-15 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    assign tick       = (div_cnt == DIV_LAST);
    assign frame_edge = tick && (index == 2'd3);
    assign dp         = 1'b1;

    always_comb begin
        cur_digit = display[{index, 2'b00} +: 4];
        cur_blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        case (index)
            2'd3:    cur_blank = (display[15:12] == 4'd0);
            2'd2:    cur_blank = (display[15:8] == 8'd0);
            2'd1:    cur_blank = (display[15:4] == 12'd0);
            default: cur_blank = 1'b0;
        endcase
`endif
    end

    // digits_valid is a one-cycle strobe with no back-pressure: every asserted cycle
    // is a capture, and the value only reaches the screen at the next frame boundary.
    always_ff @(posedge clock) begin
        if (clear) begin
            div_cnt    <= '0;
            index      <= 2'd0;
            shadow     <= 16'd0;
            display    <= 16'd0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            frame_done <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick)
                index <= index + 2'd1;
            if (digits_valid)
                shadow <= digits;
            // A strobe on the boundary edge itself bypasses the shadow so it is not lost a frame.
            if (frame_edge)
                display <= digits_valid ? digits : shadow;
            frame_done <= frame_edge;
            if (tick || cur_blank) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
            end else begin
                an  <= ~(4'b0001 << index);
                seg <= decode(cur_digit);
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: per-cycle scoreboard against a cycle model, a digit-pattern
// table checked one full frame after each load, and hand-written reset/boundary sequences.
module tb_seven_seg_scan;
    localparam int CLK_DIV = 4;

    logic        clock;
    logic        clear;
    logic [15:0] digits;
    logic        digits_valid;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    int tests;
    int errors;

    seven_seg_scan #(.CLK_DIV(CLK_DIV)) dut (
        .clock(clock),
        .clear(clear),
        .digits(digits),
        .digits_valid(digits_valid),
        .seg(seg),
        .an(an),
        .dp(dp),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected {an, seg, frame_done} pushed when an edge is driven, popped after it.
    logic [11:0] exp_q[$];

    logic [6:0] seg_lut [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    int          m_div = 0;
    int          m_idx = 0;
    logic [15:0] m_shadow = 16'd0;
    logic [15:0] m_disp = 16'd0;

    function automatic logic lead_blank(input logic [15:0] disp, input int idx);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (idx == 0)
            return 1'b0;
        return (disp >> (idx * 4)) == 16'd0;
`else
        return (idx < 0) && (disp == 16'd0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [15:0] d);
        logic [11:0] exp_w;
        logic [11:0] got_w;
        logic        tk;
        logic        fd;
        logic [3:0]  nib;
        clear = c;
        digits_valid = v;
        digits = d;
        if (c) begin
            exp_w = {4'b1111, 7'b1111111, 1'b0};
            m_div = 0;
            m_idx = 0;
            m_shadow = 16'd0;
            m_disp = 16'd0;
        end else begin
            tk  = (m_div == CLK_DIV - 1);
            fd  = tk && (m_idx == 3);
            nib = m_disp[m_idx*4 +: 4];
            if (tk || lead_blank(m_disp, m_idx))
                exp_w = {4'b1111, 7'b1111111, fd};
            else
                exp_w = {~(4'b0001 << m_idx), seg_lut[nib], fd};
            if (fd)
                m_disp = v ? d : m_shadow;
            if (v)
                m_shadow = d;
            m_div = tk ? 0 : m_div + 1;
            if (tk)
                m_idx = (m_idx + 1) % 4;
        end
        exp_q.push_back(exp_w);
        @(posedge clock);
        #1;
        got_w = {an, seg, frame_done};
        check("scoreboard", got_w, exp_q.pop_front());
        check("dp_off", dp, 1);
        check("an_onehot", (an == 4'b1111) || $onehot(~an), 1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'($urandom_range(0, 65535)));
    endtask

    typedef struct {
        logic [15:0] digits;
        logic [27:0] exp_segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [5];

    initial begin
        int          cnt;
        int          fd_cnt;
        logic [27:0] got_segs;
        logic [6:0]  lz;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        lz = 7'b1111111;
`else
        lz = 7'b1000000;
`endif
        vecs[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{16'h00A7, {lz, lz, 7'b0111111, 7'b1111000}};
        vecs[2] = '{16'h5678, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
        vecs[3] = '{16'h90EF, {7'b0010000, 7'b1000000, 7'b0111111, 7'b0111111}};
        vecs[4] = '{16'h000C, {lz, lz, lz, 7'b0111111}};

        tests = 0;
        errors = 0;
        clear = 1'b1;
        digits_valid = 1'b0;
        digits = 16'd0;
        @(posedge clock);
        #1;

        // Reset, release, and slot spacing.
        step(1'b1, 1'b0, 16'hFFFF);
        step(1'b1, 1'b1, 16'hFFFF);
        check("reset_an", an, 4'b1111);
        check("reset_seg", seg, 7'b1111111);
        check("reset_frame_done", frame_done, 0);
        idle();
        check("release_an", an, 4'b1110);
        check("release_seg", seg, 7'b1000000);
        cnt = 0;
        while (an != 4'b1101 && cnt < 100) begin
            idle();
            cnt++;
        end
        check("digit1_delay", cnt, CLK_DIV);

        // Mid-frame loads from the table; the scoreboard covers the no-tearing window.
        for (int v = 0; v < 5; v++) begin
            cnt = 0;
            while (an != 4'b1101 && cnt < 8 * CLK_DIV) begin
                idle();
                cnt++;
            end
            step(1'b0, 1'b1, vecs[v].digits);
            cnt = 0;
            do begin
                idle();
                cnt++;
            end while (frame_done !== 1'b1 && cnt < 5 * CLK_DIV);
            check("frame_done_seen", frame_done, 1);
            got_segs = '1;
            for (int s = 0; s < 4 * CLK_DIV - 1; s++) begin
                idle();
                for (int i = 0; i < 4; i++)
                    if (an == ~(4'b0001 << i))
                        got_segs[i*7 +: 7] = seg;
            end
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d_digit%0d_seg", v, i),
                      got_segs[i*7 +: 7], vecs[v].exp_segs[i*7 +: 7]);
        end

        // Strobe coincident with the index-3 tick loads the display directly.
        cnt = 0;
        while (!(m_idx == 3 && m_div == CLK_DIV - 1) && cnt < 8 * CLK_DIV) begin
            idle();
            cnt++;
        end
        step(1'b0, 1'b1, 16'h9999);
        check("coincident_frame_done", frame_done, 1);
        fd_cnt = 0;
        got_segs = '1;
        for (int s = 0; s < 4 * CLK_DIV - 1; s++) begin
            idle();
            if (frame_done)
                fd_cnt++;
            for (int i = 0; i < 4; i++)
                if (an == ~(4'b0001 << i))
                    got_segs[i*7 +: 7] = seg;
        end
        check("coincident_single_pulse", fd_cnt, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("coincident_digit%0d_seg", i), got_segs[i*7 +: 7], 7'b0010000);
        idle();
        check("next_frame_done", frame_done, 1);

        // Clear while digit 2 is being scanned.
        cnt = 0;
        while (an != 4'b1011 && cnt < 8 * CLK_DIV) begin
            idle();
            cnt++;
        end
        check("reached_digit2", an, 4'b1011);
        step(1'b1, 1'b1, 16'h4321);
        check("midclear_an", an, 4'b1111);
        check("midclear_seg", seg, 7'b1111111);
        check("midclear_frame_done", frame_done, 0);
        idle();
        check("midclear_restart_an", an, 4'b1110);
        check("midclear_restart_seg", seg, 7'b1000000);
        cnt = 0;
        while (an != 4'b1101 && cnt < 100) begin
            idle();
            cnt++;
        end
        check("midclear_digit1_delay", cnt, CLK_DIV);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
